// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the RegisterFile write port between ALU (A) and load (B) writeback.
// Grants are combinational; the winning write is registered onto wrtEn/rd/wrtData one cycle later.
module regfile_write_arbiter #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int DBITS               = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           hold,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] a_rd,
  input  logic [DBITS-1:0]               a_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] b_rd,
  input  logic [DBITS-1:0]               b_data,
  output logic                           wrtEn,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rd,
  output logic [DBITS-1:0]               wrtData,
  output logic                           last_b
);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_t;

  pri_t state, state_next;
  logic grant_a, grant_b;

  // Grants imply the matching valid, so a grant is already a transfer.
  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    state_next = state;
    if (!hold && !reset) begin
      if (a_valid && (!b_valid || state == PRI_A)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
    if (grant_a) begin
      state_next = PRI_B;
    end else if (grant_b) begin
      state_next = PRI_A;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PRI_A;
    end else begin
      state <= state_next;
    end
  end

  // Payload registers hold their last value when no transfer occurs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrtEn   <= 1'b0;
      rd      <= '0;
      wrtData <= '0;
      last_b  <= 1'b0;
    end else begin
      wrtEn <= grant_a | grant_b;
      if (grant_a) begin
        rd      <= a_rd;
        wrtData <= a_data;
        last_b  <= 1'b0;
      end else if (grant_b) begin
        rd      <= b_rd;
        wrtData <= b_data;
        last_b  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single requesters, fairness, hold,
// same-register collision and reset in mid-stream.
module tb_regfile_write_arbiter;

  localparam int RW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hold = 1'b0;
  logic          a_valid = 1'b0;
  logic          b_valid = 1'b0;
  logic [RW-1:0] a_rd = '0;
  logic [RW-1:0] b_rd = '0;
  logic [DW-1:0] a_data = '0;
  logic [DW-1:0] b_data = '0;
  logic          a_ready, b_ready, wrtEn, last_b;
  logic [RW-1:0] rd;
  logic [DW-1:0] wrtData;

  int n_checks = 0;
  int n_errors = 0;

  // Register r5 of the downstream RegisterFile.
  logic [DW-1:0] r5 = '0;

  regfile_write_arbiter #(
    .REG_INDEX_BIT_WIDTH(RW),
    .DBITS(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hold(hold),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_rd(a_rd),
    .a_data(a_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .b_rd(b_rd),
    .b_data(b_data),
    .wrtEn(wrtEn),
    .rd(rd),
    .wrtData(wrtData),
    .last_b(last_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wrtEn && rd == 4'd5) r5 <= wrtData;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_valid = 1'b1; a_rd = 4'd7; a_data = 32'h0000_0077;
    #2;
    n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("FAIL rst_a_ready: got %b exp 0", a_ready); end
    n_checks++; if (b_ready !== 1'b0) begin n_errors++; $display("FAIL rst_b_ready: got %b exp 0", b_ready); end
    n_checks++; if (wrtEn !== 1'b0) begin n_errors++; $display("FAIL rst_wrten: got %b exp 0", wrtEn); end
    n_checks++; if (rd !== 4'd0) begin n_errors++; $display("FAIL rst_rd: got %0d exp 0", rd); end
    n_checks++; if (wrtData !== 32'h0) begin n_errors++; $display("FAIL rst_data: got %h exp 0", wrtData); end
    n_checks++; if (last_b !== 1'b0) begin n_errors++; $display("FAIL rst_last_b: got %b exp 0", last_b); end
    step();
    n_checks++; if (wrtEn !== 1'b0) begin n_errors++; $display("FAIL rst_wrten_edge: got %b exp 0", wrtEn); end
    reset = 1'b0;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL rst_rel_a_ready: got %b exp 1", a_ready); end
    step();
    a_valid = 1'b0;
    n_checks++; if (wrtEn !== 1'b1) begin n_errors++; $display("FAIL rst_rel_wrten: got %b exp 1", wrtEn); end
    n_checks++; if (rd !== 4'd7) begin n_errors++; $display("FAIL rst_rel_rd: got %0d exp 7", rd); end
    n_checks++; if (wrtData !== 32'h77) begin n_errors++; $display("FAIL rst_rel_data: got %h exp 77", wrtData); end
    #1;
    n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("FAIL rst_idle_a_ready: got %b exp 0", a_ready); end
    step();
    n_checks++; if (wrtEn !== 1'b0) begin n_errors++; $display("FAIL rst_idle_wrten: got %b exp 0", wrtEn); end
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_rd = 4'd3; a_data = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL sa_a_ready: got %b exp 1", a_ready); end
    n_checks++; if (b_ready !== 1'b0) begin n_errors++; $display("FAIL sa_b_ready: got %b exp 0", b_ready); end
    step();
    a_valid = 1'b0;
    n_checks++; if (wrtEn !== 1'b1) begin n_errors++; $display("FAIL sa_wrten: got %b exp 1", wrtEn); end
    n_checks++; if (rd !== 4'd3) begin n_errors++; $display("FAIL sa_rd: got %0d exp 3", rd); end
    n_checks++; if (wrtData !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL sa_data: got %h exp deadbeef", wrtData); end
    n_checks++; if (last_b !== 1'b0) begin n_errors++; $display("FAIL sa_last_b: got %b exp 0", last_b); end
    step();
    n_checks++; if (wrtEn !== 1'b0) begin n_errors++; $display("FAIL sa_wrten_after: got %b exp 0", wrtEn); end
    n_checks++; if (rd !== 4'd3) begin n_errors++; $display("FAIL sa_rd_hold: got %0d exp 3", rd); end
  endtask

  task automatic test_single_b();
    b_valid = 1'b1; b_rd = 4'd9; b_data = 32'hCAFE_F00D;
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL sb_b_ready: got %b exp 1", b_ready); end
    n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("FAIL sb_a_ready: got %b exp 0", a_ready); end
    step();
    b_valid = 1'b0;
    n_checks++; if (wrtEn !== 1'b1) begin n_errors++; $display("FAIL sb_wrten: got %b exp 1", wrtEn); end
    n_checks++; if (rd !== 4'd9) begin n_errors++; $display("FAIL sb_rd: got %0d exp 9", rd); end
    n_checks++; if (wrtData !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL sb_data: got %h exp cafef00d", wrtData); end
    n_checks++; if (last_b !== 1'b1) begin n_errors++; $display("FAIL sb_last_b: got %b exp 1", last_b); end
    step();
    n_checks++; if (wrtEn !== 1'b0) begin n_errors++; $display("FAIL sb_wrten_after: got %b exp 0", wrtEn); end
  endtask

  task automatic test_contention();
    a_valid = 1'b1; a_rd = 4'd1; a_data = 32'hA000_0000;
    b_valid = 1'b1; b_rd = 4'd2; b_data = 32'hB000_0000;
    for (int i = 0; i < 4; i++) begin
      logic          exp_b;
      logic [RW-1:0] exp_rd;
      logic [DW-1:0] exp_d;
      exp_b  = i[0];
      exp_rd = exp_b ? 4'd2 : 4'd1;
      exp_d  = exp_b ? b_data : a_data;
      #1;
      n_checks++; if (a_ready !== !exp_b) begin n_errors++; $display("FAIL ctn_a_ready[%0d]: got %b exp %b", i, a_ready, !exp_b); end
      n_checks++; if (b_ready !== exp_b) begin n_errors++; $display("FAIL ctn_b_ready[%0d]: got %b exp %b", i, b_ready, exp_b); end
      step();
      n_checks++; if (wrtEn !== 1'b1) begin n_errors++; $display("FAIL ctn_wrten[%0d]: got %b exp 1", i, wrtEn); end
      n_checks++; if (rd !== exp_rd) begin n_errors++; $display("FAIL ctn_rd[%0d]: got %0d exp %0d", i, rd, exp_rd); end
      n_checks++; if (last_b !== exp_b) begin n_errors++; $display("FAIL ctn_last_b[%0d]: got %b exp %b", i, last_b, exp_b); end
      n_checks++; if (wrtData !== exp_d) begin n_errors++; $display("FAIL ctn_data[%0d]: got %h exp %h", i, wrtData, exp_d); end
      if (exp_b) b_data = b_data + 32'd1;
      else a_data = a_data + 32'd1;
      if (i == 3) begin
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
    end
    step();
    n_checks++; if (wrtEn !== 1'b0) begin n_errors++; $display("FAIL ctn_wrten_end: got %b exp 0", wrtEn); end
  endtask

  task automatic test_hold();
    a_valid = 1'b1; a_rd = 4'd4; a_data = 32'h44;
    b_valid = 1'b1; b_rd = 4'd6; b_data = 32'h66;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL hold_pre_a_ready: got %b exp 1", a_ready); end
    step();
    a_data = 32'h45;
    hold = 1'b1;
    n_checks++; if (wrtEn !== 1'b1 || rd !== 4'd4) begin n_errors++; $display("FAIL hold_committed: got wrtEn=%b rd=%0d exp wrtEn=1 rd=4", wrtEn, rd); end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_errors++; $display("FAIL hold_ready[%0d]: got a=%b b=%b exp 0 0", i, a_ready, b_ready); end
      step();
      n_checks++; if (wrtEn !== 1'b0) begin n_errors++; $display("FAIL hold_wrten[%0d]: got %b exp 0", i, wrtEn); end
    end
    hold = 1'b0;
    #1;
    n_checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin n_errors++; $display("FAIL hold_resume_ready: got a=%b b=%b exp a=0 b=1", a_ready, b_ready); end
    step();
    b_valid = 1'b0;
    n_checks++; if (wrtEn !== 1'b1 || rd !== 4'd6 || wrtData !== 32'h66 || last_b !== 1'b1) begin
      n_errors++; $display("FAIL hold_resume_b: got wrtEn=%b rd=%0d data=%h last_b=%b exp 1 6 66 1", wrtEn, rd, wrtData, last_b);
    end
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL hold_then_a_ready: got %b exp 1", a_ready); end
    step();
    a_valid = 1'b0;
    n_checks++; if (wrtEn !== 1'b1 || rd !== 4'd4 || wrtData !== 32'h45 || last_b !== 1'b0) begin
      n_errors++; $display("FAIL hold_then_a: got wrtEn=%b rd=%0d data=%h last_b=%b exp 1 4 45 0", wrtEn, rd, wrtData, last_b);
    end
    b_valid = 1'b1; b_data = 32'h67;
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL hold_b_only_ready: got %b exp 1", b_ready); end
    step();
    b_valid = 1'b0;
    n_checks++; if (wrtData !== 32'h67 || last_b !== 1'b1) begin n_errors++; $display("FAIL hold_b_only: got data=%h last_b=%b exp 67 1", wrtData, last_b); end
    step();
    n_checks++; if (wrtEn !== 1'b0) begin n_errors++; $display("FAIL hold_idle_wrten: got %b exp 0", wrtEn); end
  endtask

  task automatic test_collision();
    a_valid = 1'b1; a_rd = 4'd5; a_data = 32'h11;
    b_valid = 1'b1; b_rd = 4'd5; b_data = 32'h22;
    #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_errors++; $display("FAIL col_first_ready: got a=%b b=%b exp a=1 b=0", a_ready, b_ready); end
    step();
    a_valid = 1'b0;
    n_checks++; if (wrtEn !== 1'b1 || rd !== 4'd5 || wrtData !== 32'h11 || last_b !== 1'b0) begin
      n_errors++; $display("FAIL col_first_write: got wrtEn=%b rd=%0d data=%h last_b=%b exp 1 5 11 0", wrtEn, rd, wrtData, last_b);
    end
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL col_second_ready: got %b exp 1", b_ready); end
    step();
    b_valid = 1'b0;
    n_checks++; if (wrtEn !== 1'b1 || rd !== 4'd5 || wrtData !== 32'h22 || last_b !== 1'b1) begin
      n_errors++; $display("FAIL col_second_write: got wrtEn=%b rd=%0d data=%h last_b=%b exp 1 5 22 1", wrtEn, rd, wrtData, last_b);
    end
    step();
    n_checks++; if (wrtEn !== 1'b0) begin n_errors++; $display("FAIL col_idle_wrten: got %b exp 0", wrtEn); end
    n_checks++; if (r5 !== 32'h22) begin n_errors++; $display("FAIL col_r5_final: got %h exp 22", r5); end
  endtask

  task automatic test_reset_midstream();
    a_valid = 1'b1; a_rd = 4'd8; a_data = 32'h88;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL mid_a_ready: got %b exp 1", a_ready); end
    step();
    n_checks++; if (wrtEn !== 1'b1 || rd !== 4'd8) begin n_errors++; $display("FAIL mid_inflight: got wrtEn=%b rd=%0d exp 1 8", wrtEn, rd); end
    a_rd = 4'd10; a_data = 32'hAA;
    b_valid = 1'b1; b_rd = 4'd9; b_data = 32'h99;
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL mid_pri_b_ready: got %b exp 1", b_ready); end
    reset = 1'b1;
    #1;
    n_checks++; if (wrtEn !== 1'b0) begin n_errors++; $display("FAIL mid_async_wrten: got %b exp 0", wrtEn); end
    n_checks++; if (rd !== 4'd0) begin n_errors++; $display("FAIL mid_async_rd: got %0d exp 0", rd); end
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_errors++; $display("FAIL mid_rst_ready: got a=%b b=%b exp 0 0", a_ready, b_ready); end
    step();
    n_checks++; if (wrtEn !== 1'b0) begin n_errors++; $display("FAIL mid_rst_edge_wrten: got %b exp 0", wrtEn); end
    reset = 1'b0;
    #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_errors++; $display("FAIL mid_rel_ready: got a=%b b=%b exp a=1 b=0", a_ready, b_ready); end
    step();
    a_valid = 1'b0;
    n_checks++; if (wrtEn !== 1'b1 || rd !== 4'd10 || wrtData !== 32'hAA || last_b !== 1'b0) begin
      n_errors++; $display("FAIL mid_rel_a: got wrtEn=%b rd=%0d data=%h last_b=%b exp 1 10 aa 0", wrtEn, rd, wrtData, last_b);
    end
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL mid_rel_b_ready: got %b exp 1", b_ready); end
    step();
    b_valid = 1'b0;
    n_checks++; if (wrtEn !== 1'b1 || rd !== 4'd9 || wrtData !== 32'h99 || last_b !== 1'b1) begin
      n_errors++; $display("FAIL mid_rel_b: got wrtEn=%b rd=%0d data=%h last_b=%b exp 1 9 99 1", wrtEn, rd, wrtData, last_b);
    end
    step();
    n_checks++; if (wrtEn !== 1'b0) begin n_errors++; $display("FAIL mid_idle_wrten: got %b exp 0", wrtEn); end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_single_b();
    test_contention();
    test_hold();
    test_collision();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
